// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises 10-bit command words from MOSI for the RAM stage
// and serialises the RAM read byte back out on MISO.
module spi_slave_ctrl #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int TXC_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic                frame_state_s;
  logic                shifting_s;
  logic                last_bit_s;
  logic                tx_load_s;

  logic [CNT_W-1:0]    bit_cnt_r;
  logic [FRAME_W-2:0]  shreg_r;
  logic [FRAME_W-1:0]  rx_data_r;
  logic                rx_valid_r;
  logic                rd_addr_done_r;
  logic [DATA_W-1:0]   tx_shreg_r;
  logic [TXC_W-1:0]    tx_cnt_r;
  logic                tx_used_r;
  logic                miso_r;

  assign MISO     = miso_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and per-cycle datapath enables
  always_comb begin
    next_state_s  = state_r;
    frame_state_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!SS_n) next_state_s = CHK_CMD;
        else       next_state_s = IDLE;
      end
      CHK_CMD: begin
        if (SS_n)                next_state_s = IDLE;
        else if (!MOSI)          next_state_s = WRITE;
        else if (rd_addr_done_r) next_state_s = READ_DATA;
        else                     next_state_s = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        frame_state_s = 1'b1;
        if (SS_n) next_state_s = IDLE;
        else      next_state_s = state_r;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    // bit_cnt_r parks at FRAME_W once the word is in, so trailing MOSI bits are ignored
    shifting_s = frame_state_s && !SS_n && (bit_cnt_r < CNT_W'(FRAME_W));
    last_bit_s = shifting_s && (bit_cnt_r == CNT_W'(FRAME_W - 1));
    // One read byte per frame, accepted only once the strobe has gone
    tx_load_s  = (state_r == READ_DATA) && !SS_n && (bit_cnt_r == CNT_W'(FRAME_W)) &&
                 !rx_valid_r && !tx_used_r && tx_valid;
  end

  // Receive shifter, command strobe, read-address tracking and MISO serialiser
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r      <= '0;
      shreg_r        <= '0;
      rx_data_r      <= '0;
      rx_valid_r     <= 1'b0;
      rd_addr_done_r <= 1'b0;
      tx_shreg_r     <= '0;
      tx_cnt_r       <= '0;
      tx_used_r      <= 1'b0;
      miso_r         <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      if (!frame_state_s || SS_n) begin
        bit_cnt_r <= '0;
        tx_cnt_r  <= '0;
        tx_used_r <= 1'b0;
        miso_r    <= 1'b0;
      end else begin
        if (shifting_s) begin
          shreg_r   <= {shreg_r[FRAME_W-3:0], MOSI};
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            rx_data_r  <= {shreg_r, MOSI};
            rx_valid_r <= 1'b1;
            if (state_r == READ_ADD)       rd_addr_done_r <= 1'b1;
            else if (state_r == READ_DATA) rd_addr_done_r <= 1'b0;
            else                           rd_addr_done_r <= rd_addr_done_r;
          end
        end
        // tx_cnt_r counts the MISO bits still being presented, including the current one
        if (tx_load_s) begin
          miso_r     <= tx_data[DATA_W-1];
          tx_shreg_r <= {tx_data[DATA_W-2:0], 1'b0};
          tx_cnt_r   <= TXC_W'(DATA_W);
          tx_used_r  <= 1'b1;
        end else if (tx_cnt_r > TXC_W'(1)) begin
          miso_r     <= tx_shreg_r[DATA_W-1];
          tx_shreg_r <= {tx_shreg_r[DATA_W-2:0], 1'b0};
          tx_cnt_r   <= tx_cnt_r - TXC_W'(1);
        end else begin
          miso_r   <= 1'b0;
          tx_cnt_r <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomised self-checking bench for spi_slave_ctrl against a frame-level reference model.
module tb_spi_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   model_rad;      // reference: a read address has been received and not yet consumed
  logic [9:0] last_rx;  // reference: last word delivered

  spi_slave_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rxv"}, {15'd0, rx_valid}, 16'd0);
    chk({tag, "_miso"}, {15'd0, MISO}, 16'd0);
  endtask

  // One SPI transaction: selector, abort_at word bits (10 = full word), optional read byte.
  task automatic frame(input bit sel, input logic [9:0] word, input int abort_at,
                       input logic [7:0] byte_v, input int tx_delay, input bit noise,
                       input int rst_at);
    bit rd_data;
    rd_data = sel && model_rad;
    SS_n = 1'b0; MOSI = 1'($urandom);
    tx_valid = noise ? 1'($urandom) : 1'b0; tx_data = 8'($urandom);
    tick(); chk_quiet("ss_fall");
    MOSI = sel;
    tick(); chk_quiet("selector");
    for (int i = 0; i < abort_at; i++) begin
      MOSI = word[9-i];
      tx_valid = noise ? 1'($urandom) : 1'b0; tx_data = 8'($urandom);
      tick();
      chk("word_rxv", {15'd0, rx_valid}, (i == 9) ? 16'd1 : 16'd0);
      chk("word_miso", {15'd0, MISO}, 16'd0);
      if (i == 9) chk("rx_data", {6'd0, rx_data}, {6'd0, word});
    end
    if (abort_at < 10) begin
      SS_n = 1'b1; tx_valid = 1'b0;
      tick(); chk_quiet("abort");
      chk("abort_hold", {6'd0, rx_data}, {6'd0, last_rx});
      tick(); chk_quiet("abort_idle");
      return;
    end
    last_rx = word;
    if (sel) model_rad = !model_rad;
    MOSI = 1'($urandom); tx_valid = 1'b0;
    tick(); chk_quiet("strobe_end");
    chk("rx_hold", {6'd0, rx_data}, {6'd0, word});
    for (int d = 0; d < tx_delay; d++) begin
      MOSI = 1'($urandom);
      tick(); chk_quiet("tx_wait");
    end
    if (rd_data) begin
      tx_valid = 1'b1; tx_data = byte_v;
      tick(); chk("miso_b7", {15'd0, MISO}, {15'd0, byte_v[7]});
      for (int j = 6; j >= 0; j--) begin
        tx_valid = noise ? 1'($urandom) : 1'b0; tx_data = 8'($urandom); MOSI = 1'($urandom);
        if (rst_at == j) begin
          rst = 1'b1;
          tick(); chk_quiet("rst_mid");
          chk("rst_rxdata", {6'd0, rx_data}, 16'd0);
          rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
          last_rx = 10'd0; model_rad = 1'b0;
          tick(); chk_quiet("rst_after");
          return;
        end
        tick(); chk("miso_bit", {15'd0, MISO}, {15'd0, byte_v[j]});
      end
      tx_valid = 1'b0;
      tick(); chk_quiet("miso_done");
    end else begin
      for (int k = 0; k < 3; k++) begin
        tx_valid = 1'b1; tx_data = byte_v; MOSI = 1'($urandom);
        tick(); chk_quiet("tx_ignored");
      end
    end
    SS_n = 1'b1; tx_valid = 1'b0;
    tick(); chk_quiet("ss_rise");
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    tick(); tick();
    chk_quiet("reset");
    chk("reset_rxdata", {6'd0, rx_data}, 16'd0);
    rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0; MOSI = 1'b0;
    model_rad = 1'b0; last_rx = 10'd0;
    tick(); chk_quiet("post_reset");
  endtask

  initial begin
    do_reset();
    // Directed sequence from the block's usage scenarios
    frame(1'b0, 10'h005, 10, 8'h00, 0, 1'b0, -1);
    frame(1'b0, 10'h1AA, 10, 8'h00, 0, 1'b1, -1);
    frame(1'b1, 10'h205, 10, 8'h3C, 1, 1'b1, -1);
    frame(1'b1, 10'h3C7, 10, 8'hA5, 1, 1'b0, -1);
    frame(1'b0, 10'h0F0, 5,  8'h00, 0, 1'b0, -1);
    frame(1'b0, 10'h155, 10, 8'h00, 0, 1'b0, -1);
    // Read pair with reset in the middle of MISO shifting
    frame(1'b1, 10'h211, 10, 8'h00, 0, 1'b0, -1);
    frame(1'b1, 10'h300, 10, 8'hC3, 2, 1'b1, 3);
    // Reset after a read address must forget it: next selector-1 frame is an address
    frame(1'b1, 10'h27E, 10, 8'h00, 0, 1'b0, -1);
    do_reset();
    frame(1'b1, 10'h2AA, 10, 8'h5A, 0, 1'b0, -1);
    frame(1'b1, 10'h399, 10, 8'h81, 0, 1'b0, -1);
    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      frame(1'($urandom), 10'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 10,
            8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
